// File: rtl/camera_ray_gen.sv
// Primary ray generator: latches camera words once per frame and walks the pixel raster,
// emitting one ray per pixel over a valid/ready handshake.
module camera_ray_gen #(
  parameter int unsigned       H_RES = 640,
  parameter int unsigned       V_RES = 480,
  parameter logic signed [15:0] FOCAL = 16'sd256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [31:0]        camera_pos,
  input  logic [31:0]        camera_dir,
  output logic               ray_valid,
  input  logic               ray_ready,
  output logic [31:0]        ray_origin,
  output logic signed [15:0] ray_dir_x,
  output logic signed [15:0] ray_dir_y,
  output logic signed [15:0] ray_dir_z,
  output logic [9:0]         pixel_x,
  output logic [9:0]         pixel_y,
  output logic               sof,
  output logic               eol,
  output logic               frame_done,
  output logic               cam_pending
);

  localparam logic [9:0]  LastX = 10'(H_RES - 1);
  localparam logic [9:0]  LastY = 10'(V_RES - 1);
  localparam logic [15:0] HalfH = 16'(H_RES / 2);
  localparam logic [15:0] OffY  = 16'(V_RES / 2 - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StEmit, StFrameEnd} state_e;

  state_e      state_q, state_d;
  logic [21:0] pos_q, pos_d;
  logic [21:0] dir_q, dir_d;
  logic [9:0]  px_q, px_d;
  logic [9:0]  py_q, py_d;
  logic        handshake;
  logic        last_px;
  logic        last_py;

  assign handshake = (state_q == StEmit) & ray_ready;
  assign last_px   = (px_q == LastX);
  assign last_py   = (py_q == LastY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:     if (enable) state_d = StLoad;
      StLoad:     state_d = StEmit;
      StEmit:     if (handshake && last_px && last_py) state_d = StFrameEnd;
      StFrameEnd: state_d = enable ? StLoad : StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q <= '0;
      dir_q <= '0;
      px_q  <= '0;
      py_q  <= '0;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
      px_q  <= px_d;
      py_q  <= py_d;
    end
  end

  // Camera words are only adopted in LOAD so a whole frame sees one camera.
  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    px_d  = px_q;
    py_d  = py_q;
    if (state_q == StLoad) begin
      pos_d = camera_pos[21:0];
      dir_d = camera_dir[21:0];
      px_d  = '0;
      py_d  = '0;
    end else if (handshake) begin
      if (last_px) begin
        px_d = '0;
        if (!last_py) py_d = py_q + 10'd1;
      end else begin
        px_d = px_q + 10'd1;
      end
    end
  end

  always_comb begin
    ray_valid   = (state_q == StEmit);
    frame_done  = (state_q == StFrameEnd);
    ray_origin  = {10'b0, pos_q};
    pixel_x     = px_q;
    pixel_y     = py_q;
    sof         = ray_valid & (px_q == 10'd0) & (py_q == 10'd0);
    eol         = ray_valid & last_px;
    cam_pending = (camera_pos[21:0] != pos_q) | (camera_dir[21:0] != dir_q);
    ray_dir_x   = '0;
    ray_dir_y   = '0;
    ray_dir_z   = '0;
    // Directions are zero outside EMIT so reset and idle present a clean bus.
    if (ray_valid) begin
      ray_dir_x = $signed({{6{dir_q[21]}}, dir_q[21:12]} + {6'b0, px_q} - HalfH);
      ray_dir_y = $signed({{6{dir_q[11]}}, dir_q[11:2]} + OffY - {6'b0, py_q});
      ray_dir_z = $signed(FOCAL + {{14{dir_q[1]}}, dir_q[1:0]});
    end
  end

endmodule

// File: tb/tb_camera_ray_gen.sv
// Randomized bench for camera_ray_gen on a 4x2 raster, checked against a per-pixel reference.
module tb_camera_ray_gen;

  localparam int H = 4;
  localparam int V = 2;
  localparam int N = H * V;

  logic               clk = 1'b0;
  logic               reset;
  logic               enable;
  logic [31:0]        camera_pos;
  logic [31:0]        camera_dir;
  logic               ray_valid;
  logic               ray_ready;
  logic [31:0]        ray_origin;
  logic signed [15:0] ray_dir_x;
  logic signed [15:0] ray_dir_y;
  logic signed [15:0] ray_dir_z;
  logic [9:0]         pixel_x;
  logic [9:0]         pixel_y;
  logic               sof;
  logic               eol;
  logic               frame_done;
  logic               cam_pending;

  int checks   = 0;
  int failures = 0;

  camera_ray_gen #(
    .H_RES(H),
    .V_RES(V),
    .FOCAL(16'sd256)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .camera_pos (camera_pos),
    .camera_dir (camera_dir),
    .ray_valid  (ray_valid),
    .ray_ready  (ray_ready),
    .ray_origin (ray_origin),
    .ray_dir_x  (ray_dir_x),
    .ray_dir_y  (ray_dir_y),
    .ray_dir_z  (ray_dir_z),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .sof        (sof),
    .eol        (eol),
    .frame_done (frame_done),
    .cam_pending(cam_pending)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Signed value of a w-bit two's-complement field starting at bit lsb.
  function automatic int sfield(input logic [31:0] v, input int lsb, input int w);
    int f;
    f = int'((v >> lsb) & ((32'd1 << w) - 32'd1));
    if (f >= (1 << (w - 1))) f -= (1 << w);
    return f;
  endfunction

  task automatic check_ray(input int k, input logic [31:0] lp, input logic [31:0] ld);
    int x;
    int y;
    x = k % H;
    y = k / H;
    check_eq("pixel_x", 32'(pixel_x), 32'(x));
    check_eq("pixel_y", 32'(pixel_y), 32'(y));
    check_eq("dir_x", {16'h0, ray_dir_x}, {16'h0, 16'(sfield(ld, 12, 10) + x - H / 2)});
    check_eq("dir_y", {16'h0, ray_dir_y}, {16'h0, 16'(sfield(ld, 2, 10) + V / 2 - 1 - y)});
    check_eq("dir_z", {16'h0, ray_dir_z}, {16'h0, 16'(256 + sfield(ld, 0, 2))});
    check_eq("origin", ray_origin, lp & 32'h003F_FFFF);
    check_eq("sof", 32'(sof), 32'(x == 0 && y == 0));
    check_eq("eol", 32'(eol), 32'(x == H - 1));
  endtask

  // Entered at a negedge one edge before LOAD; the inputs present now are what LOAD latches.
  task automatic run_frame(input int pct, input bit hold_en, input int change_at,
                           input logic [31:0] new_dir, input int stop_at, output int cycles);
    logic [31:0] lp;
    logic [31:0] ld;
    int          k;
    int          cyc;
    int          limit;
    bit          changed;
    bit          pend_chk;
    lp       = camera_pos;
    ld       = camera_dir;
    k        = 0;
    cyc      = 0;
    changed  = 1'b0;
    pend_chk = 1'b0;
    limit    = (stop_at > 0) ? stop_at : N;
    @(negedge clk);
    cyc++;
    enable = hold_en;
    check_eq("load_valid", 32'(ray_valid), 32'd0);
    while (k < limit && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ray_valid) begin
        check_ray(k, lp, ld);
        if (k == 0) check_eq("cam_pending_clear", 32'(cam_pending), 32'd0);
        if (changed && !pend_chk) begin
          check_eq("cam_pending_set", 32'(cam_pending), 32'd1);
          pend_chk = 1'b1;
        end
        ray_ready = ($urandom_range(99) < pct);
        if (ray_ready) k++;
        if (k == change_at && !changed) begin
          camera_dir = new_dir;
          changed    = 1'b1;
        end
      end else begin
        check_eq("emit_valid", 32'(ray_valid), 32'd1);
      end
    end
    if (cyc >= 200) check_eq("frame_timeout", 32'(k), 32'(limit));
    if (stop_at == 0) begin
      @(negedge clk);
      cyc++;
      check_eq("frame_done", 32'(frame_done), 32'd1);
      check_eq("end_valid", 32'(ray_valid), 32'd0);
    end
    cycles = cyc;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_valid"}, 32'(ray_valid), 32'd0);
    check_eq({tag, "_done"}, 32'(frame_done), 32'd0);
    check_eq({tag, "_px"}, 32'(pixel_x), 32'd0);
    check_eq({tag, "_py"}, 32'(pixel_y), 32'd0);
    check_eq({tag, "_origin"}, ray_origin, 32'd0);
    check_eq({tag, "_dx"}, {16'h0, ray_dir_x}, 32'd0);
    check_eq({tag, "_dy"}, {16'h0, ray_dir_y}, 32'd0);
    check_eq({tag, "_dz"}, {16'h0, ray_dir_z}, 32'd0);
    check_eq({tag, "_sof"}, 32'(sof), 32'd0);
    check_eq({tag, "_eol"}, 32'(eol), 32'd0);
  endtask

  initial begin
    int          cyc;
    logic [31:0] dir_a;
    reset      = 1'b0;
    enable     = 1'b0;
    ray_ready  = 1'b0;
    camera_pos = '0;
    camera_dir = '0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check_eq("reset_pending", 32'(cam_pending), 32'd0);
    camera_pos = 32'hFFC0_0001;
    #1;
    check_eq("pending_pos", 32'(cam_pending), 32'd1);
    camera_pos = 32'hFFC0_0000;
    #1;
    check_eq("pending_upper_ignored", 32'(cam_pending), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic frame, zero direction, ready held high.
    camera_pos = 32'h0012_3456;
    camera_dir = '0;
    ray_ready  = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    run_frame(100, 1'b0, -1, '0, 0, cyc);
    check_eq("period_single", 32'(cyc), 32'(N + 2));
    repeat (2) begin
      @(negedge clk);
      check_eq("idle_valid", 32'(ray_valid), 32'd0);
      check_eq("idle_done", 32'(frame_done), 32'd0);
    end

    // Negative/positive field sign extension and origin masking.
    camera_pos = 32'hFFFF_FFFF;
    camera_dir = (32'h3FD << 12) | (32'd5 << 2) | 32'd3;
    enable     = 1'b1;
    run_frame(100, 1'b0, -1, '0, 0, cyc);

    // Random cameras with random back-pressure.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      camera_pos = $urandom;
      camera_dir = $urandom;
      enable     = 1'b1;
      run_frame(50, 1'b0, -1, '0, 0, cyc);
    end

    // Camera change mid-frame, then back-to-back frames with enable held.
    @(negedge clk);
    dir_a      = $urandom;
    camera_dir = dir_a;
    camera_pos = $urandom;
    ray_ready  = 1'b1;
    enable     = 1'b1;
    run_frame(100, 1'b1, 3, dir_a ^ 32'h0000_1004, 0, cyc);
    run_frame(100, 1'b1, -1, '0, 0, cyc);
    check_eq("period_b2b_1", 32'(cyc), 32'(N + 2));
    run_frame(100, 1'b0, -1, '0, 0, cyc);
    check_eq("period_b2b_2", 32'(cyc), 32'(N + 2));

    // Reset at pixel (2,1), then restart from (0,0).
    @(negedge clk);
    camera_pos = $urandom;
    camera_dir = $urandom;
    ray_ready  = 1'b1;
    enable     = 1'b1;
    run_frame(100, 1'b0, -1, '0, 6, cyc);
    @(negedge clk);
    check_eq("pre_reset_px", 32'(pixel_x), 32'd2);
    check_eq("pre_reset_py", 32'(pixel_y), 32'd1);
    reset = 1'b0;
    #1;
    check_quiet("midreset");
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("post_reset_done", 32'(frame_done), 32'd0);
      check_eq("post_reset_valid", 32'(ray_valid), 32'd0);
    end
    enable = 1'b1;
    run_frame(100, 1'b0, -1, '0, 0, cyc);
    check_eq("period_restart", 32'(cyc), 32'(N + 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
